// File: rtl/button_debounce_4ch.sv
// Four-channel pushbutton conditioner: 2-flop synchroniser, per-channel debounce FSM, press strobes and key encoder.
// Latency: 2 cycles to sync2, then DEBOUNCE_CYCLES to btn_level/btn_press; key_valid follows btn_press by 1 cycle.
// Backpressure: none, free-running. Every output is registered and sampled every cycle.
//
// Ports:
//   clkin      - system clock, rising edge
//   reset_n    - asynchronous active-low reset
//   btn_raw    - raw asynchronous buttons, bit 0 = a ... bit 3 = d
//   btn_level  - debounced levels for the LED timer a-d inputs
//   btn_press  - one-cycle strobe per channel on an accepted 0->1 transition
//   key_valid  - one-cycle key event strobe
//   key_code   - index of the pressed channel, valid while key_valid = 1
//   multi_err  - one-cycle strobe on simultaneous presses (MULTI_PRESS_REJECT_EN builds only)
//
// Configuration macro: MULTI_PRESS_REJECT_EN
//   defined   - simultaneous presses suppress key_valid and pulse multi_err
//   undefined - simultaneous presses report the lowest index; multi_err tied to 0
module button_debounce_4ch #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clkin,
  input  logic       reset_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic       key_valid,
  output logic [1:0] key_code,
  output logic       multi_err
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [3:0]       sync1_q, sync2_q;
  state_t           state_q [4];
  state_t           state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [3:0]       level_q, level_d;
  logic [3:0]       press_q, press_d;
  logic             key_valid_q, key_valid_d;
  logic [1:0]       key_code_q, key_code_d;
  logic [1:0]       low_idx;

  // Two-flop synchroniser; nothing downstream looks at sync1_q.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
      press_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  // The counter loads 1 on entering a WAIT state, so hitting CNT_LAST
  // means sync2 has held its new value for exactly DEBOUNCE_CYCLES cycles.
  always_comb begin
    level_d = level_q;
    press_d = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (sync2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        HELD: begin
          cnt_d[i] = '0;
          if (!sync2_q[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (sync2_q[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Lowest set index: scanning downwards lets the lowest bit win.
  always_comb begin
    low_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (press_q[i]) low_idx = 2'(i);
    end
  end

`ifdef MULTI_PRESS_REJECT_EN
  logic multi_q, multi_d;
  logic press_any, press_multi;

  assign press_any   = |press_q;
  assign press_multi = |(press_q & (press_q - 4'd1));

  always_comb begin
    key_valid_d = press_any && !press_multi;
    key_code_d  = key_code_q;
    multi_d     = press_multi;
    if (press_any && !press_multi) key_code_d = low_idx;
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) multi_q <= 1'b0;
    else          multi_q <= multi_d;
  end

  assign multi_err = multi_q;
`else
  always_comb begin
    key_valid_d = |press_q;
    key_code_d  = key_code_q;
    if (|press_q) key_code_d = low_idx;
  end

  assign multi_err = 1'b0;
`endif

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_button_debounce_4ch.sv
// Self-checking bench for button_debounce_4ch with DEBOUNCE_CYCLES = 8.
// Latency: n/a (bench). Inputs driven 1 time unit after the rising edge, outputs sampled there.
// Backpressure: n/a.
module tb_button_debounce_4ch;

  localparam int DC = 8;

  logic       clkin = 1'b0;
  logic       reset_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic       key_valid;
  logic [1:0] key_code;
  logic       multi_err;

  int n_tests = 0;
  int n_fail  = 0;

  button_debounce_4ch #(.DEBOUNCE_CYCLES(DC)) dut (
    .clkin     (clkin),
    .reset_n   (reset_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .key_valid (key_valid),
    .key_code  (key_code),
    .multi_err (multi_err)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic [3:0] raw;
    int         hold;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic       kv;
    logic [1:0] kc;
    logic       me;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic [3:0] raw, int hold, logic [3:0] lvl, logic [3:0] prs,
                              logic kv, logic [1:0] kc, logic me);
    vec_t v;
    v.raw = raw; v.hold = hold; v.lvl = lvl; v.prs = prs; v.kv = kv; v.kc = kc; v.me = me;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                         input logic kv, input logic [1:0] kc, input logic me);
    chk({tag, " btn_level"}, int'(btn_level), int'(lvl));
    chk({tag, " btn_press"}, int'(btn_press), int'(prs));
    chk({tag, " key_valid"}, int'(key_valid), int'(kv));
    chk({tag, " key_code"},  int'(key_code),  int'(kc));
    chk({tag, " multi_err"}, int'(multi_err), int'(me));
  endtask

  task automatic chk_quiet(input string tag, input logic [3:0] lvl);
    chk({tag, " btn_level"}, int'(btn_level), int'(lvl));
    chk({tag, " btn_press"}, int'(btn_press), 0);
    chk({tag, " key_valid"}, int'(key_valid), 0);
    chk({tag, " multi_err"}, int'(multi_err), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] kc_sim;
    logic       kv_sim, me_sim;
    int         presses, keys, errs, bad;

`ifdef MULTI_PRESS_REJECT_EN
    kv_sim = 1'b0; kc_sim = 2'd2; me_sim = 1'b1;
`else
    kv_sim = 1'b1; kc_sim = 2'd1; me_sim = 1'b0;
`endif

    // Clean press on c, release, then simultaneous press of b and d.
    vt.push_back(mk(4'b0100, 9, 4'b0000, 4'b0000, 1'b0, 2'd0,   1'b0));
    vt.push_back(mk(4'b0100, 1, 4'b0100, 4'b0100, 1'b0, 2'd0,   1'b0));
    vt.push_back(mk(4'b0100, 1, 4'b0100, 4'b0000, 1'b1, 2'd2,   1'b0));
    vt.push_back(mk(4'b0100, 2, 4'b0100, 4'b0000, 1'b0, 2'd2,   1'b0));
    vt.push_back(mk(4'b0000, 9, 4'b0100, 4'b0000, 1'b0, 2'd2,   1'b0));
    vt.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 1'b0, 2'd2,   1'b0));
    vt.push_back(mk(4'b0000, 3, 4'b0000, 4'b0000, 1'b0, 2'd2,   1'b0));
    vt.push_back(mk(4'b1010, 9, 4'b0000, 4'b0000, 1'b0, 2'd2,   1'b0));
    vt.push_back(mk(4'b1010, 1, 4'b1010, 4'b1010, 1'b0, 2'd2,   1'b0));
    vt.push_back(mk(4'b1010, 1, 4'b1010, 4'b0000, kv_sim, kc_sim, me_sim));
    vt.push_back(mk(4'b1010, 1, 4'b1010, 4'b0000, 1'b0, kc_sim, 1'b0));
    vt.push_back(mk(4'b0000, 9, 4'b1010, 4'b0000, 1'b0, kc_sim, 1'b0));
    vt.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 1'b0, kc_sim, 1'b0));

    // Reset state
    reset_n = 1'b0;
    btn_raw = 4'b0000;
    repeat (3) step();
    chk_all("reset", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    reset_n = 1'b1;

    // Table-driven vectors: every cycle of a row must match that row.
    for (int r = 0; r < vt.size(); r++) begin
      for (int k = 0; k < vt[r].hold; k++) begin
        btn_raw = vt[r].raw;
        step();
        chk_all($sformatf("row%0d cyc%0d", r, k), vt[r].lvl, vt[r].prs, vt[r].kv, vt[r].kc, vt[r].me);
      end
    end

    // Bounce rejection on a: toggle every 3 cycles for 40 cycles, then hold.
    for (int c = 0; c < 40; c++) begin
      btn_raw = {3'b000, ((c / 3) % 2) == 0};
      step();
      chk_quiet($sformatf("bounce cyc%0d", c), 4'b0000);
    end
    btn_raw = 4'b0001;
    for (int c = 1; c < 10; c++) begin
      step();
      chk_quiet($sformatf("bounce settle%0d", c), 4'b0000);
    end
    step();
    chk("bounce rise btn_level", int'(btn_level), 1);
    chk("bounce rise btn_press", int'(btn_press), 1);
    step();
    chk("bounce key_valid", int'(key_valid), 1);
    chk("bounce key_code", int'(key_code), 0);
    btn_raw = 4'b0000;
    repeat (12) step();
    chk_quiet("bounce released", 4'b0000);

    // Release with bounce on b.
    btn_raw = 4'b0010;
    repeat (12) step();
    chk_quiet("relb held", 4'b0010);
    for (int c = 0; c < 9; c++) begin
      btn_raw = (c < 4) ? 4'b0000 : 4'b0010;
      step();
      chk_quiet($sformatf("relb glitch%0d", c), 4'b0010);
    end
    btn_raw = 4'b0000;
    for (int c = 1; c < 10; c++) begin
      step();
      chk_quiet($sformatf("relb wait%0d", c), 4'b0010);
    end
    step();
    chk_quiet("relb fall", 4'b0000);

    // Reset mid-debounce on d.
    repeat (4) step();
    btn_raw = 4'b1000;
    repeat (6) step();
    reset_n = 1'b0;
    #1;
    chk_all("midrst async", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    repeat (2) step();
    chk_all("midrst held", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    reset_n = 1'b1;
    for (int c = 1; c < 10; c++) begin
      step();
      chk_quiet($sformatf("midrst requal%0d", c), 4'b0000);
    end
    step();
    chk("midrst rise btn_level", int'(btn_level), 8);
    chk("midrst rise btn_press", int'(btn_press), 8);
    step();
    chk("midrst key_valid", int'(key_valid), 1);
    chk("midrst key_code", int'(key_code), 3);
    btn_raw = 4'b0000;
    repeat (12) step();
    chk_quiet("midrst released", 4'b0000);

    // Long hold on a: one press strobe, one key event, level steady.
    presses = 0; keys = 0; errs = 0; bad = 0;
    btn_raw = 4'b0001;
    for (int c = 1; c <= 1000; c++) begin
      step();
      if (btn_press[0]) presses++;
      if (key_valid) keys++;
      if (multi_err) errs++;
      if ((c >= 10) != btn_level[0]) bad++;
    end
    chk("hold btn_press count", presses, 1);
    chk("hold key_valid count", keys, 1);
    chk("hold multi_err count", errs, 0);
    chk("hold level wrong cycles", bad, 0);
    chk("hold key_code", int'(key_code), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
